// File: rtl/janus_cube_pkg.sv
// Shared types and constants for the Janus cube tile scheduler.
//   sched_state_e : scheduler FSM states
//   cube_uop_t    : one tile uop at the default L0/ACC sizes
//   *_DEF         : default geometry used as parameter defaults
//   CTRL_*_BIT    : MMIO control register bit positions
package janus_cube_pkg;

    localparam int ARRAY_SIZE_DEF  = 16;
    localparam int L0_ENTRIES_DEF  = 64;
    localparam int ACC_ENTRIES_DEF = 64;
    localparam int IDX_W_DEF       = $clog2(L0_ENTRIES_DEF);
    localparam int CIDX_W_DEF      = $clog2(ACC_ENTRIES_DEF);

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_RESET_BIT  = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]  a_idx;
        logic [IDX_W_DEF-1:0]  b_idx;
        logic [CIDX_W_DEF-1:0] c_idx;
        logic                  first;
        logic                  last;
    } cube_uop_t;

endpackage

// File: rtl/janus_cube_tile_iter.sv
// Nested m/n/k tile counter (m outer, n middle, k inner).
//   clear          : synchronous return to (0,0,0); wins over advance
//   advance        : step to the next tile coordinate
//   m_lim/n_lim/k_lim : tile counts per dimension (non-zero while in use)
//   m/n/k          : current coordinate
//   m_nx/n_nx/k_nx : coordinate after one advance (lets the caller prepare
//                    the following uop in the same cycle as a handshake)
//   k_wrap         : current k is the last k of its (m,n) pair
//   last           : current coordinate is the final one of the run
module janus_cube_tile_iter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] m_lim,
    input  logic [W-1:0] n_lim,
    input  logic [W-1:0] k_lim,
    output logic [W-1:0] m,
    output logic [W-1:0] n,
    output logic [W-1:0] k,
    output logic [W-1:0] m_nx,
    output logic [W-1:0] n_nx,
    output logic [W-1:0] k_nx,
    output logic         k_wrap,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic n_wrap;
    logic m_wrap;

    assign k_wrap = (k + ONE) == k_lim;
    assign n_wrap = (n + ONE) == n_lim;
    assign m_wrap = (m + ONE) == m_lim;
    assign last   = k_wrap && n_wrap && m_wrap;

    assign k_nx = k_wrap ? '0 : k + ONE;
    assign n_nx = k_wrap ? (n_wrap ? '0 : n + ONE) : n;
    assign m_nx = (k_wrap && n_wrap) ? (m_wrap ? '0 : m + ONE) : m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            n <= '0;
            k <= '0;
        end else if (clear) begin
            m <= '0;
            n <= '0;
            k <= '0;
        end else if (advance) begin
            m <= m_nx;
            n <= n_nx;
            k <= k_nx;
        end
    end

endmodule

// File: rtl/janus_cube_uop_sched.sv
// Tile-level MATMUL scheduler for the Janus cube.
// Latches one MATMUL (M,K,N), splits it into tile uops, issues them to the
// systolic array and counts retirements to raise done.
//   clk, rst_n     : clock, asynchronous active-low reset
//   soft_rst       : synchronous reset pulse, highest priority
//   inst_wr/inst_data : instruction write, [15:0]=M [31:16]=K [47:32]=N
//   start          : launch the latched instruction
//   l0a_valid/l0b_valid : per-entry validity of the L0A/L0B buffers
//   uop_*          : issue channel to the array
//   uop_retire     : one uop has left the array pipeline
//   busy/done/err  : status; done and err are sticky until the next start
//   dbg_state      : current FSM state
//
// Issue handshake: uop_valid is registered and, once high, the uop fields
// hold until the cycle where uop_valid && uop_ready; that cycle is the
// transfer. uop_valid never drops without a transfer (except on reset).
module janus_cube_uop_sched
    import janus_cube_pkg::*;
#(
    parameter int ARRAY_SIZE  = ARRAY_SIZE_DEF,
    parameter int DIM_W       = 16,
    parameter int L0_ENTRIES  = L0_ENTRIES_DEF,
    parameter int ACC_ENTRIES = ACC_ENTRIES_DEF,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = $clog2(L0_ENTRIES),
    localparam int CIDX_W     = $clog2(ACC_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst,
    input  logic                  inst_wr,
    input  logic [63:0]           inst_data,
    input  logic                  start,
    input  logic [L0_ENTRIES-1:0] l0a_valid,
    input  logic [L0_ENTRIES-1:0] l0b_valid,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic [IDX_W-1:0]      uop_a_idx,
    output logic [IDX_W-1:0]      uop_b_idx,
    output logic [CIDX_W-1:0]     uop_c_idx,
    output logic                  uop_first,
    output logic                  uop_last,
    input  logic                  uop_retire,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output sched_state_e          dbg_state
);

    localparam int TS_LOG2 = $clog2(ARRAY_SIZE);
    localparam int TW      = DIM_W + 1;
    localparam int PW      = 2 * TW;
    localparam logic [TW-1:0] ROUND   = TW'(ARRAY_SIZE - 1);
    localparam logic [TW-1:0] ONE_T   = TW'(1);
    localparam logic [PW-1:0] L0_LIM  = PW'(L0_ENTRIES);
    localparam logic [PW-1:0] ACC_LIM = PW'(ACC_ENTRIES);
    localparam logic [TW-1:0] ZPAD    = '0;

    sched_state_e state, state_nx;

    logic [DIM_W-1:0] m_dim, k_dim, n_dim;
    logic             inst_present;
    logic [CNT_W-1:0] issued, retired, retired_nx;

    logic [TW-1:0] m_tiles, k_tiles, n_tiles;
    logic [PW-1:0] mk_prod, kn_prod, mn_prod;
    logic          zero_tiles, out_of_range;

    logic [TW-1:0] it_m, it_n, it_k, it_m_nx, it_n_nx, it_k_nx;
    logic          it_k_wrap, it_last;

    logic [TW-1:0] m_sel, n_sel, k_sel;
    logic [PW-1:0] a_full, b_full, c_full;
    logic          sel_first, sel_last, gate;

    logic hs, inst_accept, spurious;
    logic start_acc, load_uop, valid_nx, set_done, set_err, advance;

    assign m_tiles = ({1'b0, m_dim} + ROUND) >> TS_LOG2;
    assign k_tiles = ({1'b0, k_dim} + ROUND) >> TS_LOG2;
    assign n_tiles = ({1'b0, n_dim} + ROUND) >> TS_LOG2;

    assign mk_prod = {ZPAD, m_tiles} * {ZPAD, k_tiles};
    assign kn_prod = {ZPAD, k_tiles} * {ZPAD, n_tiles};
    assign mn_prod = {ZPAD, m_tiles} * {ZPAD, n_tiles};

    assign zero_tiles   = (m_tiles == '0) || (k_tiles == '0) || (n_tiles == '0);
    assign out_of_range = (mk_prod > L0_LIM) || (kn_prod > L0_LIM) || (mn_prod > ACC_LIM);

    assign hs          = uop_valid && uop_ready;
    assign inst_accept = inst_wr && ((state == IDLE) || (state == DONE));
    assign spurious    = uop_retire && (retired == issued);
    assign retired_nx  = (uop_retire && !spurious) ? retired + 1'b1 : retired;

    janus_cube_tile_iter #(.W(TW)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (soft_rst || start_acc),
        .advance (advance),
        .m_lim   (m_tiles),
        .n_lim   (n_tiles),
        .k_lim   (k_tiles),
        .m       (it_m),
        .n       (it_n),
        .k       (it_k),
        .m_nx    (it_m_nx),
        .n_nx    (it_n_nx),
        .k_nx    (it_k_nx),
        .k_wrap  (it_k_wrap),
        .last    (it_last)
    );

    // During a transfer the following uop is prepared from the iterator's
    // look-ahead coordinate, which keeps back-to-back issue at 1 uop/cycle.
    assign m_sel = hs ? it_m_nx : it_m;
    assign n_sel = hs ? it_n_nx : it_n;
    assign k_sel = hs ? it_k_nx : it_k;

    // Full-width products; the range check in CHECK guarantees the low bits
    // are the whole index for every coordinate reached in ISSUE.
    assign a_full = {ZPAD, m_sel} * {ZPAD, k_tiles} + {ZPAD, k_sel};
    assign b_full = {ZPAD, k_sel} * {ZPAD, n_tiles} + {ZPAD, n_sel};
    assign c_full = {ZPAD, m_sel} * {ZPAD, n_tiles} + {ZPAD, n_sel};

    assign sel_first = (k_sel == '0);
    assign sel_last  = (k_sel == (k_tiles - ONE_T));
    assign gate      = l0a_valid[a_full[IDX_W-1:0]] && l0b_valid[b_full[IDX_W-1:0]];

    logic unused_bits;
    assign unused_bits = ^{inst_data[63:48], a_full[PW-1:IDX_W], b_full[PW-1:IDX_W],
                           c_full[PW-1:CIDX_W], it_k_wrap};

    always_comb begin
        state_nx  = state;
        valid_nx  = uop_valid;
        load_uop  = 1'b0;
        start_acc = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && (inst_present || inst_wr)) begin
                    start_acc = 1'b1;
                    state_nx  = CHECK;
                end
            end
            CHECK: begin
                if (zero_tiles) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end else if (out_of_range) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                    set_err  = 1'b1;
                end else begin
                    state_nx = ISSUE;
                    valid_nx = gate;
                    load_uop = gate;
                end
            end
            ISSUE: begin
                if (hs) begin
                    advance = 1'b1;
                    if (it_last) begin
                        state_nx = DRAIN;
                        valid_nx = 1'b0;
                    end else begin
                        valid_nx = gate;
                        load_uop = gate;
                    end
                end else if (!uop_valid) begin
                    valid_nx = gate;
                    load_uop = gate;
                end
            end
            DRAIN: begin
                if (retired_nx == issued) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (soft_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dim        <= '0;
            k_dim        <= '0;
            n_dim        <= '0;
            inst_present <= 1'b0;
            uop_valid    <= 1'b0;
            uop_a_idx    <= '0;
            uop_b_idx    <= '0;
            uop_c_idx    <= '0;
            uop_first    <= 1'b0;
            uop_last     <= 1'b0;
            issued       <= '0;
            retired      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else if (soft_rst) begin
            m_dim        <= '0;
            k_dim        <= '0;
            n_dim        <= '0;
            inst_present <= 1'b0;
            uop_valid    <= 1'b0;
            uop_a_idx    <= '0;
            uop_b_idx    <= '0;
            uop_c_idx    <= '0;
            uop_first    <= 1'b0;
            uop_last     <= 1'b0;
            issued       <= '0;
            retired      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (inst_accept) begin
                m_dim        <= inst_data[DIM_W-1:0];
                k_dim        <= inst_data[16 +: DIM_W];
                n_dim        <= inst_data[32 +: DIM_W];
                inst_present <= 1'b1;
            end
            uop_valid <= valid_nx;
            if (load_uop) begin
                uop_a_idx <= a_full[IDX_W-1:0];
                uop_b_idx <= b_full[IDX_W-1:0];
                uop_c_idx <= c_full[CIDX_W-1:0];
                uop_first <= sel_first;
                uop_last  <= sel_last;
            end
            if (start_acc) begin
                done    <= 1'b0;
                err     <= 1'b0;
                issued  <= '0;
                retired <= '0;
            end else begin
                if (hs) begin
                    issued <= issued + 1'b1;
                end
                retired <= retired_nx;
                if (set_done) begin
                    done <= 1'b1;
                end
                if (set_err || spurious) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state == CHECK) || (state == ISSUE) || (state == DRAIN);
    assign dbg_state = state;

endmodule
